// File: rtl/calc_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_input_sequencer
// Purpose  : Front-end control stage of the calculator. Captures operand A,
//            operand B and an opcode from the switch bank on successive ENTER
//            presses, holds them on the ALU inputs, samples the ALU result in
//            a one-cycle EXEC state and presents it until the next operation.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            sw                - switch bank (operand value or opcode)
//            btn_enter/clear   - raw buttons, asynchronous to clk
//            alu_result/carry  - combinational result from the ALU mux
//            alu_a/b/op        - operand and opcode registers driving the ALU
//            result/carry_out  - registered ALU result and carry
//            done              - high while the result is valid (SHOW)
//            state_out         - current state code for LEDs/debug
// Options  : CALC_DEBOUNCE_EN  - when defined, ENTER is debounced for
//                                DEBOUNCE_CYCLES stable cycles before the
//                                edge detector.
// Revision : 1.0  initial release
// ============================================================================
module calc_input_sequencer #(
  parameter int WIDTH           = 8,
  parameter int OPW             = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // --------------------------------------------------------------------------
  // Button synchronizers
  // --------------------------------------------------------------------------
  logic r_enter_sync1, r_enter_sync2;
  logic r_clear_sync1, r_clear_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enter_sync1 <= 1'b0;
      r_enter_sync2 <= 1'b0;
      r_clear_sync1 <= 1'b0;
      r_clear_sync2 <= 1'b0;
    end else begin
      r_enter_sync1 <= btn_enter;
      r_enter_sync2 <= r_enter_sync1;
      r_clear_sync1 <= btn_clear;
      r_clear_sync2 <= r_clear_sync1;
    end
  end

  // CLEAR is level-sensitive: no edge detection, no debounce.
  logic w_clear;
  assign w_clear = r_clear_sync2;

  // --------------------------------------------------------------------------
  // ENTER conditioning: optional debounce, then rising-edge detect
  // --------------------------------------------------------------------------
  logic w_enter_level;

`ifdef CALC_DEBOUNCE_EN
  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [c_cnt_w-1:0] r_db_cnt;
  logic               r_db;

  // The debounced level only follows the synced input after it has differed
  // from it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_db     <= 1'b0;
    end else if (r_enter_sync2 == r_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_cnt_max) begin
      r_db     <= ~r_db;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_enter_level = r_db;
`else
  assign w_enter_level = r_enter_sync2;
`endif

  logic r_enter_prev;
  logic w_enter_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enter_prev <= 1'b0;
    end else begin
      r_enter_prev <= w_enter_level;
    end
  end

  // One pulse per press regardless of how long the button is held.
  assign w_enter_pulse = w_enter_level & ~r_enter_prev;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_GET_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_clear) begin
      w_state_next = S_GET_A;
    end else begin
      case (r_state)
        S_GET_A:  if (w_enter_pulse) w_state_next = S_GET_B;
        S_GET_B:  if (w_enter_pulse) w_state_next = S_GET_OP;
        S_GET_OP: if (w_enter_pulse) w_state_next = S_EXEC;
        S_EXEC:   w_state_next = S_SHOW;
        // Chained entry: the press in SHOW is already operand A.
        S_SHOW:   if (w_enter_pulse) w_state_next = S_GET_B;
        default:  w_state_next = S_GET_A;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Operand, opcode and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_GET_A: begin
          if (w_enter_pulse) alu_a <= sw;
        end
        S_GET_B: begin
          if (w_enter_pulse) alu_b <= sw;
        end
        S_GET_OP: begin
          if (w_enter_pulse) alu_op <= sw[OPW-1:0];
        end
        S_EXEC: begin
          // Operands have been stable for at least one full cycle here.
          result    <= alu_result;
          carry_out <= alu_carry;
          done      <= 1'b1;
        end
        S_SHOW: begin
          if (w_enter_pulse) begin
            alu_a <= sw;
            done  <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = r_state;

endmodule
`default_nettype wire
